jcapture_trigbuf: RTL and testbench

- Triggered logic-analyser sample buffer on the upstream side of the JTAG capture path.
- Samples a probe bundle (e.g. fastram addr/wr/req/ack/strobes) on qualified clock enables into a ring RAM, keeping PRE samples of pre-trigger history.
- On a mask/value trigger, captures the post-trigger window, then streams the whole window oldest-first over a valid/ready port to the capture/readout stage.

---
 rtl/jcapture_pkg.sv | 18 +
 rtl/jcapture_trigbuf_if.sv | 9 +
 rtl/jcapture_ringram.sv | 19 +
 rtl/jcapture_trigbuf.sv | 158 +++++++++++++++
 tb/tb_jcapture_trigbuf.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/jcapture_pkg.sv
// jcapture_pkg: shared state type and helpers for the JTAG capture path blocks
package jcapture_pkg;

    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE, READ} state_e;

    localparam int MATCH_W = 64;

    function automatic int post_count(input int depth, input int pre);
        return depth - pre - 1;
    endfunction

    function automatic logic trig_match(input logic [MATCH_W-1:0] d,
                                        input logic [MATCH_W-1:0] value,
                                        input logic [MATCH_W-1:0] mask);
        return ((d ^ value) & mask) == '0;
    endfunction

endpackage

// File: rtl/jcapture_trigbuf_if.sv
// jcapture_trigbuf_if: valid/ready readout stream of captured samples
interface jcapture_trigbuf_if #(parameter int WIDTH = 29);
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_last;
    modport master (output rd_valid, rd_data, rd_last, input rd_ready);
    modport slave  (input rd_valid, rd_data, rd_last, output rd_ready);
endinterface

// File: rtl/jcapture_ringram.sv
// jcapture_ringram: simple dual-port DEPTH x WIDTH ring RAM with registered read
module jcapture_ringram #(
    parameter int WIDTH  = 29,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata_q
);
    logic [WIDTH-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end
endmodule

// File: rtl/jcapture_trigbuf.sv
// jcapture_trigbuf: triggered sample ring buffer streaming the captured window oldest-first
module jcapture_trigbuf
    import jcapture_pkg::*;
#(
    parameter int WIDTH  = 29,
    parameter int ADDR_W = 8,
    parameter int PRE    = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             sample_en,
    input  logic             arm,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [WIDTH-1:0] trig_value,
    output logic             busy,
    output logic             triggered,
    output logic             done,
    jcapture_trigbuf_if.master rd
);
    localparam int DEPTH  = 2**ADDR_W;
    localparam int POST_N = post_count(DEPTH, PRE);
    localparam logic [ADDR_W-1:0] PRE_A    = ADDR_W'(PRE);
    localparam logic [ADDR_W-1:0] PRE_M1   = ADDR_W'(PRE - 1);
    localparam logic [ADDR_W-1:0] POST_M1  = ADDR_W'(POST_N - 1);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_M1 = (ADDR_W+1)'(DEPTH - 1);

    if (PRE < 0 || PRE >= DEPTH) begin : g_bad_pre
        $fatal(1, "jcapture_trigbuf: PRE=%0d outside 0..%0d", PRE, DEPTH - 1);
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, trig_ptr_q, trig_ptr_d;
    logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
    logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
    logic              busy_q, busy_d, triggered_q, triggered_d, done_q, done_d;
    logic              rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic              sample, hit, xfer, re;
    logic [WIDTH-1:0]  ram_q;

    jcapture_ringram #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .we      (sample),
        .waddr   (wr_ptr_q),
        .wdata   (d),
        .re      (re),
        .raddr   (rd_ptr_q),
        .rdata_q (ram_q)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        trig_ptr_d  = trig_ptr_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        triggered_d = triggered_q;
        done_d      = done_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        re          = 1'b0;
        sample      = sample_en && !arm && (state_q inside {FILL, ARMED, POST});
        hit         = trig_match(MATCH_W'(d), MATCH_W'(trig_value), MATCH_W'(trig_mask));
        xfer        = rd_valid_q && rd.rd_ready;
        wr_ptr_d    = sample ? wr_ptr_q + 1'b1 : wr_ptr_q;
        if (arm) begin
            state_d     = (PRE == 0) ? ARMED : FILL;
            pre_cnt_d   = '0;
            triggered_d = 1'b0;
            done_d      = 1'b0;
            rd_valid_d  = 1'b0;
            rd_last_d   = 1'b0;
        end else begin
            case (state_q)
                FILL: if (sample) begin
                    pre_cnt_d = pre_cnt_q + 1'b1;
                    state_d   = (pre_cnt_q == PRE_M1) ? ARMED : FILL;
                end
                ARMED: if (sample && hit) begin
                    trig_ptr_d  = wr_ptr_q;
                    triggered_d = 1'b1;
                    post_cnt_d  = '0;
                    state_d     = (POST_N == 0) ? DONE : POST;
                    done_d      = (POST_N == 0);
                end
                POST: if (sample) begin
                    post_cnt_d = post_cnt_q + 1'b1;
                    state_d    = (post_cnt_q == POST_M1) ? DONE : POST;
                    done_d     = (post_cnt_q == POST_M1);
                end
                DONE: begin
                    rd_ptr_d = trig_ptr_q - PRE_A;
                    rd_cnt_d = '0;
                    state_d  = READ;
                end
                READ: begin
                    // Refill the output register whenever it is empty or being drained.
                    re = (!rd_valid_q || rd.rd_ready) && (rd_cnt_q != DEPTH_C);
                    if (re) begin
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        rd_cnt_d   = rd_cnt_q + 1'b1;
                        rd_valid_d = 1'b1;
                        rd_last_d  = (rd_cnt_q == DEPTH_M1);
                    end
                    if (xfer && rd_last_q) begin
                        state_d    = IDLE;
                        done_d     = 1'b0;
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        busy_d = state_d inside {FILL, ARMED, POST};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            trig_ptr_q  <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            busy_q      <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            trig_ptr_q  <= trig_ptr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            busy_q      <= busy_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    assign busy        = busy_q;
    assign triggered   = triggered_q;
    assign done        = done_q;
    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_last  = rd_last_q;
    assign rd.rd_data  = rd_valid_q ? ram_q : '0;

endmodule

// File: tb/tb_jcapture_trigbuf.sv
// tb_jcapture_trigbuf: three PRE variants (4, 0, 15) of a 16-deep buffer against a sample-list model
module tb_jcapture_trigbuf;
    localparam int W = 29;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         sample_en = 1'b0;
    logic         rd_ready = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] trig_mask = '0;
    logic [W-1:0] trig_value = '0;
    logic [2:0]   arm = '0;
    logic         busy_w [3];
    logic         trig_w [3];
    logic         done_w [3];
    logic         val_w  [3];
    logic         last_w [3];
    logic [W-1:0] data_w [3];
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        jcapture_trigbuf_if #(.WIDTH(W)) rif ();
        assign rif.rd_ready = rd_ready;
        jcapture_trigbuf #(.WIDTH(W), .ADDR_W(4), .PRE(g == 0 ? 4 : g == 1 ? 0 : 15)) dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .d          (d),
            .sample_en  (sample_en),
            .arm        (arm[g]),
            .trig_mask  (trig_mask),
            .trig_value (trig_value),
            .busy       (busy_w[g]),
            .triggered  (trig_w[g]),
            .done       (done_w[g]),
            .rd         (rif)
        );
        assign val_w[g]  = rif.rd_valid;
        assign last_w[g] = rif.rd_last;
        assign data_w[g] = rif.rd_data;
    end

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input int k);
        chkb("zero_busy", busy_w[k], 1'b0);
        chkb("zero_triggered", trig_w[k], 1'b0);
        chkb("zero_done", done_w[k], 1'b0);
        chkb("zero_rd_valid", val_w[k], 1'b0);
        chkb("zero_rd_last", last_w[k], 1'b0);
        chkd("zero_rd_data", data_w[k], '0);
    endtask

    // One capture on instance k: model keeps every sample taken since arm; the
    // window is PRE samples before the first post-FILL hit plus the rest after it.
    task automatic capture(input int k, input bit rnd_d, input logic [W-1:0] d0,
                           input logic [W-1:0] mask, input logic [W-1:0] value,
                           input int en_per, input bit rnd_rdy, input int abort_at,
                           input bit rst_post, input bit pre_armed);
        logic [W-1:0] smp[$];
        logic [W-1:0] dv;
        int pre, postn, n, t, xf, first;
        bit en, cmp, xfer;
        pre = (k == 0) ? 4 : (k == 1) ? 0 : 15;
        postn = 15 - pre;
        n = 0; t = -1; xf = 0; first = -1; cmp = 1'b0;
        trig_mask = mask;
        trig_value = value;
        if (!pre_armed) begin
            arm[k] = 1'b1;
            sample_en = 1'b1;
            @(negedge clk);
            arm[k] = 1'b0;
        end
        chkb("busy_after_arm", busy_w[k], 1'b1);
        chkb("trig_after_arm", trig_w[k], 1'b0);
        chkb("done_after_arm", done_w[k], 1'b0);
        chkb("valid_after_arm", val_w[k], 1'b0);
        for (int c = 0; c < 1000 && !cmp; c++) begin
            en = (c % en_per) == 0;
            dv = rnd_d ? W'($urandom) : d0 + W'(c);
            sample_en = en;
            d = dv;
            if (en) begin
                smp.push_back(dv);
                if (n >= pre && t < 0 && ((dv ^ value) & mask) == '0) t = n;
                n++;
            end
            cmp = t >= 0 && n == t + postn + 1;
            @(negedge clk);
            chkb("busy", busy_w[k], !cmp);
            chkb("triggered", trig_w[k], t >= 0);
            chkb("done", done_w[k], cmp);
            if (rst_post && t >= 0 && !cmp && n > t + 1) begin
                #2 reset_n = 1'b0;
                #1 check_zero(k);
                @(negedge clk);
                reset_n = 1'b1;
                sample_en = 1'b0;
                return;
            end
        end
        sample_en = 1'b0;
        if (!cmp) return;
        for (int c = 0; c < 400 && xf < 16; c++) begin
            if (abort_at > 0 && xf == abort_at) begin
                arm[k] = 1'b1;
                rd_ready = 1'b0;
                @(negedge clk);
                arm[k] = 1'b0;
                chkb("abort_rd_valid", val_w[k], 1'b0);
                chkb("abort_busy", busy_w[k], 1'b1);
                chkb("abort_done", done_w[k], 1'b0);
                return;
            end
            if (c < 2) chkb("early_rd_valid", val_w[k], 1'b0);
            if (first >= 0 && !rnd_rdy) chkb("no_bubble", val_w[k], 1'b1);
            if (val_w[k]) begin
                if (first < 0) first = c;
                chkd("rd_data", data_w[k], smp[t - pre + xf]);
                chkb("rd_last", last_w[k], xf == 15);
                chkb("done_during_read", done_w[k], 1'b1);
            end
            rd_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            xfer = val_w[k] && rd_ready;
            @(negedge clk);
            if (xfer) xf++;
        end
        rd_ready = 1'b0;
        chkb("transfer_count_16", xf == 16, 1'b1);
        chkb("rd_valid_after_last", val_w[k], 1'b0);
        chkb("done_after_last", done_w[k], 1'b0);
        chkb("busy_after_last", busy_w[k], 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) check_zero(k);
        reset_n = 1'b1;
        @(negedge clk);
        capture(0, 1'b0, 29'd0, 29'h1FFFFFFF, 29'd20, 1, 1'b0, 0, 1'b0, 1'b0);
        capture(0, 1'b0, 29'd17, 29'h1F, 29'd18, 1, 1'b0, 0, 1'b0, 1'b0);
        capture(0, 1'b1, 29'd0, 29'h3, 29'h1, 4, 1'b0, 0, 1'b0, 1'b0);
        capture(0, 1'b1, 29'd0, 29'h3, 29'h2, 1, 1'b1, 0, 1'b0, 1'b0);
        capture(1, 1'b1, 29'd0, 29'h0, 29'h0, 1, 1'b1, 0, 1'b0, 1'b0);
        capture(2, 1'b0, 29'd100, 29'h1FFFFFFF, 29'd140, 2, 1'b1, 0, 1'b0, 1'b0);
        capture(0, 1'b1, 29'd0, 29'h1, 29'h1, 1, 1'b1, 5, 1'b0, 1'b0);
        capture(0, 1'b1, 29'd0, 29'h7, 29'h5, 1, 1'b1, 0, 1'b0, 1'b1);
        capture(0, 1'b0, 29'd300, 29'h1FFFFFFF, 29'd310, 1, 1'b0, 0, 1'b1, 1'b0);
        capture(0, 1'b0, 29'd500, 29'h1FFFFFFF, 29'd530, 3, 1'b1, 0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
